// File: rtl/edge_window_assembler.sv
// edge_window_assembler: gathers 3-pixel ROM columns into a sliding 3x3 window
// with window-centre coordinates and an end-of-frame pulse.
module edge_window_assembler #(
    parameter int ROW   = 125,
    parameter int NROWS = 250,
    parameter int PIX_W = 8,
    parameter int RW    = ($clog2(NROWS) > 8) ? $clog2(NROWS) : 8,
    parameter int CW    = ($clog2(ROW) > 7) ? $clog2(ROW) : 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic [9*PIX_W-1:0] window,
    output logic               win_valid,
    output logic [RW-1:0]      center_row,
    output logic [CW-1:0]      center_col,
    output logic               frame_done
);
    logic [1:0]         step_q, step_d;
    logic [PIX_W-1:0]   top_q, top_d, mid_q, mid_d;
    logic [9*PIX_W-1:0] win_q, win_d;
    logic [CW-1:0]      col_q, col_d, ccol_q, ccol_d;
    logic [RW-1:0]      row_q, row_d, crow_q, crow_d;
    logic               valid_q, valid_d, done_q, done_d;
    logic [3*PIX_W-1:0] col_in;
    logic               last_col, last_row;

    assign col_in   = {pix_data, mid_q, top_q};
    assign last_col = col_q == CW'(ROW - 1);
    assign last_row = row_q == RW'(NROWS - 3);

    always_comb begin
        step_d  = step_q;
        top_d   = top_q;
        mid_d   = mid_q;
        win_d   = win_q;
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        crow_d  = crow_q;
        ccol_d  = ccol_q;
        if (clear) begin
            step_d = '0;
            col_d  = '0;
            row_d  = '0;
        end else if (pix_valid) begin
            step_d = (step_q == 2'd2) ? 2'd0 : step_q + 2'd1;
            top_d  = (step_q == 2'd0) ? pix_data : top_q;
            mid_d  = (step_q == 2'd1) ? pix_data : mid_q;
            if (step_q == 2'd2) begin
                for (int r = 0; r < 3; r++) begin
                    win_d[PIX_W*(3*r)   +: PIX_W] = win_q[PIX_W*(3*r+1) +: PIX_W];
                    win_d[PIX_W*(3*r+1) +: PIX_W] = win_q[PIX_W*(3*r+2) +: PIX_W];
                    win_d[PIX_W*(3*r+2) +: PIX_W] = col_in[PIX_W*r +: PIX_W];
                end
                col_d   = last_col ? '0 : col_q + CW'(1);
                row_d   = last_col ? (last_row ? '0 : row_q + RW'(1)) : row_q;
                // the first two columns of a strip only prime the window
                valid_d = col_q >= CW'(2);
                done_d  = valid_d && last_col && last_row;
                crow_d  = valid_d ? row_q + RW'(1) : crow_q;
                ccol_d  = valid_d ? col_q - CW'(1) : ccol_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q  <= '0;
            top_q   <= '0;
            mid_q   <= '0;
            win_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            crow_q  <= '0;
            ccol_q  <= '0;
        end else begin
            step_q  <= step_d;
            top_q   <= top_d;
            mid_q   <= mid_d;
            win_q   <= win_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            crow_q  <= crow_d;
            ccol_q  <= ccol_d;
        end
    end

    assign window     = win_q;
    assign win_valid  = valid_q;
    assign center_row = crow_q;
    assign center_col = ccol_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_edge_window_assembler.sv
// tb_edge_window_assembler: random/directed pixel streams scored against a
// column-count reference model through an expected-window queue.
module tb_edge_window_assembler;
    localparam int ROW   = 5;
    localparam int NROWS = 4;
    localparam int PW    = 8;

    logic            clk = 1'b0, reset = 1'b0, clear = 1'b0, pix_valid = 1'b0;
    logic [PW-1:0]   pix_data = '0;
    logic [9*PW-1:0] window;
    logic            win_valid, frame_done;
    logic [7:0]      center_row;
    logic [6:0]      center_col;

    typedef struct {
        logic [9*PW-1:0] w;
        int              row;
        int              col;
        bit              done;
        int              due;
    } exp_t;

    exp_t          q[$];
    exp_t          m_e;
    logic [PW-1:0] part[$];
    logic [3*PW-1:0] hist[3];
    int ncol = 0, cyc = 0, checks = 0, fails = 0, pulses = 0, dones = 0, p0 = 0;

    edge_window_assembler #(.ROW(ROW), .NROWS(NROWS), .PIX_W(PW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .pix_valid(pix_valid),
        .pix_data(pix_data), .window(window), .win_valid(win_valid),
        .center_row(center_row), .center_col(center_col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // One input cycle; the model sees a column as three accepted pixels and
    // derives strip/column from how many columns have completed since restart.
    task automatic drive(input bit v, input logic [PW-1:0] d, input bit c);
        exp_t e;
        int ci, st;
        @(negedge clk);
        pix_valid = v;
        pix_data  = d;
        clear     = c;
        if (c) begin
            part.delete();
            ncol = 0;
        end else if (v) begin
            part.push_back(d);
            if (part.size() == 3) begin
                hist[0] = hist[1];
                hist[1] = hist[2];
                hist[2] = {part[2], part[1], part[0]};
                part.delete();
                ci = ncol % ROW;
                st = (ncol / ROW) % (NROWS - 2);
                ncol++;
                if (ci >= 2) begin
                    for (int k = 0; k < 3; k++)
                        for (int r = 0; r < 3; r++)
                            e.w[PW*(3*r+k) +: PW] = hist[k][PW*r +: PW];
                    e.row  = st + 1;
                    e.col  = ci - 1;
                    e.done = (st == NROWS - 3) && (ci == ROW - 1);
                    e.due  = cyc + 1;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0);
    endtask

    task automatic send(input logic [PW-1:0] d, input int maxgap);
        idle(int'($urandom_range(maxgap, 0)));
        drive(1'b1, d, 1'b0);
    endtask

    task automatic send_col(input int st, input int c, input int maxgap);
        for (int r = 0; r < 3; r++) send(PW'((st + r) * ROW + c), maxgap);
    endtask

    task automatic rand_col();
        for (int r = 0; r < 3; r++) send(PW'($urandom), 2);
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due < cyc) begin
            checks++;
            fails++;
            $display("FAIL missing_win: win_valid 0 at cycle %0d, expected 1", q[0].due);
            void'(q.pop_front());
        end
        if (win_valid) begin
            pulses++;
            if (frame_done) dones++;
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_win: win_valid 1 at cycle %0d, expected 0", cyc);
            end else begin
                m_e = q.pop_front();
                chk("latency", 72'(cyc), 72'(m_e.due));
                chk("window", window, m_e.w);
                chk("center_row", 72'(center_row), 72'(m_e.row));
                chk("center_col", 72'(center_col), 72'(m_e.col));
                chk("frame_done", 72'(frame_done), 72'(m_e.done));
            end
        end else if (frame_done) begin
            checks++;
            fails++;
            $display("FAIL done_without_valid: frame_done 1, expected 0 at cycle %0d", cyc);
        end
    end

    initial begin
        hist[0] = '0;
        hist[1] = '0;
        hist[2] = '0;
        repeat (2) @(negedge clk);
        chk("rst_window", window, '0);
        chk("rst_valid", 72'(win_valid), 0);
        chk("rst_center", 72'({center_row, center_col}), 0);
        chk("rst_done", 72'(frame_done), 0);
        reset = 1'b1;
        for (int n = 0; n < 2 * ROW; n++) send_col(n / ROW, n % ROW, 0);
        send_col(0, 0, 0);
        send_col(0, 1, 0);
        idle(3);
        chk("pulses_frame1", 72'(pulses), 6);
        chk("dones_frame1", 72'(dones), 1);
        for (int n = 2; n < 2 * ROW; n++) send_col(n / ROW, n % ROW, 5);
        idle(3);
        chk("pulses_frame2", 72'(pulses), 12);
        chk("dones_frame2", 72'(dones), 2);
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'hBB, 1'b0);
        drive(1'b0, '0, 1'b1);
        p0 = pulses;
        rand_col();
        rand_col();
        idle(2);
        chk("clear_no_win", 72'(pulses), 72'(p0));
        rand_col();
        idle(2);
        chk("clear_third_col", 72'(pulses), 72'(p0 + 1));
        drive(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 3; i++) rand_col();
        idle(2);
        chk("clear_valid_drop", 72'(pulses), 72'(p0 + 2));
        repeat (400) begin
            if ($urandom_range(39, 0) == 0) drive(1'($urandom), PW'($urandom), 1'b1);
            else send(PW'($urandom), 3);
        end
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) rand_col();
        @(negedge clk);
        pix_valid = 1'b0;
        chk("pre_rst_valid", 72'(win_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_window", window, '0);
        chk("mid_rst_valid", 72'(win_valid), 0);
        chk("mid_rst_center", 72'({center_row, center_col}), 0);
        chk("mid_rst_done", 72'(frame_done), 0);
        part.delete();
        ncol = 0;
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (300) begin
            if ($urandom_range(49, 0) == 0) drive(1'($urandom), PW'($urandom), 1'b1);
            else send(PW'($urandom), 2);
        end
        idle(5);
        chk("queue_empty", 72'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
